round_controller: RTL and testbench

- Sequences one countdown round around the countdown timer stage, which sits directly downstream of this block.
- Converts raw active-low start/ack pushbuttons into the timer's run enable (timer_run = 1 counts; 0 reloads the preset).
- Consumes the timer's done level and drives a blinking expiry alarm.
- Keeps a two-digit BCD count of completed rounds for HEX display.

---
 rtl/round_controller.sv | 141 ++++++++++++++
 tb/tb_round_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Countdown round sequencer: debounced start/ack keys, timer run enable,
// blinking expiry alarm and a two-digit BCD count of completed rounds.
module round_controller #(
    parameter int BLINK_HALF   = 12500000,
    parameter int ALARM_CYCLES = 250000000,
    parameter int LOCKOUT      = 500000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_key,
    input  logic       ack_key,
    input  logic       done,
    output logic       timer_run,
    output logic       alarm_led,
    output logic [3:0] rounds_tens,
    output logic [3:0] rounds_ones,
    output logic [1:0] state
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ALARM = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t          state_q, state_n;
    logic            start_s1, start_s2, start_prev;
    logic            ack_s1, ack_s2, ack_prev;
    logic [LW-1:0]   start_lock, ack_lock;
    logic            start_pulse, ack_pulse;
    logic            done_prev, done_rise;
    logic [BW-1:0]   blink_cnt, blink_cnt_n;
    logic [AW-1:0]   alarm_cnt, alarm_cnt_n;
    logic            led_n;
    logic [3:0]      tens_n, ones_n;

    assign state       = state_q;
    assign start_pulse = ~start_s2 & start_prev & (start_lock == '0);
    assign ack_pulse   = ~ack_s2 & ack_prev & (ack_lock == '0);
    assign done_rise   = done & ~done_prev;

    // Lockout counters load LOCKOUT-1 so that LOCKOUT cycles elapse before re-arming.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_s1   <= 1'b1;
            start_s2   <= 1'b1;
            start_prev <= 1'b1;
            ack_s1     <= 1'b1;
            ack_s2     <= 1'b1;
            ack_prev   <= 1'b1;
            start_lock <= '0;
            ack_lock   <= '0;
            done_prev  <= 1'b0;
        end else begin
            start_s1   <= start_key;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            ack_s1     <= ack_key;
            ack_s2     <= ack_s1;
            ack_prev   <= ack_s2;
            done_prev  <= done;
            if (start_pulse)
                start_lock <= LW'(LOCKOUT - 1);
            else if (start_lock != '0)
                start_lock <= start_lock - LW'(1);
            if (ack_pulse)
                ack_lock <= LW'(LOCKOUT - 1);
            else if (ack_lock != '0)
                ack_lock <= ack_lock - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            timer_run   <= 1'b0;
            alarm_led   <= 1'b0;
            blink_cnt   <= '0;
            alarm_cnt   <= '0;
            rounds_tens <= '0;
            rounds_ones <= '0;
        end else begin
            state_q     <= state_n;
            timer_run   <= (state_n == RUN) || (state_n == ALARM);
            alarm_led   <= led_n;
            blink_cnt   <= blink_cnt_n;
            alarm_cnt   <= alarm_cnt_n;
            rounds_tens <= tens_n;
            rounds_ones <= ones_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        blink_cnt_n = '0;
        alarm_cnt_n = '0;
        led_n       = 1'b0;
        tens_n      = rounds_tens;
        ones_n      = rounds_ones;
        case (state_q)
            IDLE: begin
                if (start_pulse && !done)
                    state_n = RUN;
            end
            RUN: begin
                if (done_rise) begin
                    state_n = ALARM;
                    led_n   = 1'b1;
                    if (rounds_ones == 4'd9) begin
                        ones_n = 4'd0;
                        tens_n = (rounds_tens == 4'd9) ? 4'd0 : rounds_tens + 4'd1;
                    end else begin
                        ones_n = rounds_ones + 4'd1;
                    end
                end else if (start_pulse) begin
                    state_n = IDLE;
                end
            end
            ALARM: begin
                if (ack_pulse || alarm_cnt == AW'(ALARM_CYCLES - 1)) begin
                    state_n = IDLE;
                end else begin
                    alarm_cnt_n = alarm_cnt + AW'(1);
                    if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                        led_n = ~alarm_led;
                    end else begin
                        blink_cnt_n = blink_cnt + BW'(1);
                        led_n       = alarm_led;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed self-checking bench for round_controller with short timing parameters.
module tb_round_controller;

    localparam int BH = 4;
    localparam int AC = 40;
    localparam int LO = 3;

    logic       clk;
    logic       resetn;
    logic       start_key;
    logic       ack_key;
    logic       done;
    logic       timer_run;
    logic       alarm_led;
    logic [3:0] rounds_tens;
    logic [3:0] rounds_ones;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    round_controller #(
        .BLINK_HALF  (BH),
        .ALARM_CYCLES(AC),
        .LOCKOUT     (LO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_key  (start_key),
        .ack_key    (ack_key),
        .done       (done),
        .timer_run  (timer_run),
        .alarm_led  (alarm_led),
        .rounds_tens(rounds_tens),
        .rounds_ones(rounds_ones),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges; inputs are driven and outputs sampled 2 ns after each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_start();
        start_key = 1'b0;
        cyc(1);
        start_key = 1'b1;
        cyc(2);
    endtask

    task automatic press_ack();
        ack_key = 1'b0;
        cyc(1);
        ack_key = 1'b1;
        cyc(2);
    endtask

    task automatic do_round();
        press_start();
        done = 1'b1;
        cyc(1);
        press_ack();
        done = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(1);
        total++;
        if ({state, timer_run, alarm_led, rounds_tens, rounds_ones} !== 12'h000) begin
            bad++;
            $display("FAIL reset_init: got state=%b run=%b led=%b rounds=%h%h expected 00 0 0 00",
                     state, timer_run, alarm_led, rounds_tens, rounds_ones);
        end
        resetn = 1'b1;
        cyc(2);
    endtask

    task automatic test_start_path();
        start_key = 1'b0;
        cyc(1);
        start_key = 1'b1;
        total++;
        if (state !== 2'b00) begin bad++; $display("FAIL start_edge1: got %b expected 00", state); end
        cyc(1);
        total++;
        if (state !== 2'b00) begin bad++; $display("FAIL start_edge2: got %b expected 00", state); end
        cyc(1);
        total++;
        if (state !== 2'b01 || timer_run !== 1'b1) begin
            bad++;
            $display("FAIL start_edge3: got state=%b run=%b expected 01 1", state, timer_run);
        end
        done = 1'b1;
        cyc(1);
        total++;
        if (state !== 2'b10 || rounds_tens !== 4'd0 || rounds_ones !== 4'd1 || alarm_led !== 1'b1) begin
            bad++;
            $display("FAIL done_to_alarm: got state=%b rounds=%h%h led=%b expected 10 01 1",
                     state, rounds_tens, rounds_ones, alarm_led);
        end
        press_ack();
        total++;
        if (state !== 2'b00 || timer_run !== 1'b0 || alarm_led !== 1'b0) begin
            bad++;
            $display("FAIL ack_exit: got state=%b run=%b led=%b expected 00 0 0", state, timer_run, alarm_led);
        end
        done = 1'b0;
        cyc(1);
    endtask

    task automatic test_bounce();
        start_key = 1'b0;
        cyc(1);
        start_key = 1'b1;
        cyc(1);
        start_key = 1'b0;
        cyc(1);
        start_key = 1'b1;
        total++;
        if (state !== 2'b01) begin bad++; $display("FAIL bounce_enter: got %b expected 01", state); end
        cyc(5);
        total++;
        if (state !== 2'b01) begin bad++; $display("FAIL bounce_no_abort: got %b expected 01", state); end
        press_start();
        total++;
        if (state !== 2'b00 || rounds_ones !== 4'd1) begin
            bad++;
            $display("FAIL bounce_abort: got state=%b ones=%0d expected 00 1", state, rounds_ones);
        end
    endtask

    task automatic test_alarm_autoreturn();
        logic exp_led;
        int   led_bad;
        press_start();
        done = 1'b1;
        cyc(1);
        led_bad = 0;
        for (int k = 0; k < AC; k++) begin
            exp_led = (((k / BH) % 2) == 0);
            total++;
            if (state !== 2'b10 || alarm_led !== exp_led) begin
                bad++;
                $display("FAIL blink_k%0d: got state=%b led=%b expected 10 %b", k, state, alarm_led, exp_led);
            end
            cyc(1);
        end
        total++;
        if (state !== 2'b00 || timer_run !== 1'b0 || alarm_led !== 1'b0 || rounds_ones !== 4'd2) begin
            bad++;
            $display("FAIL auto_return: got state=%b run=%b led=%b ones=%0d expected 00 0 0 2",
                     state, timer_run, alarm_led, rounds_ones);
        end
        done = 1'b0;
        cyc(1);
        press_start();
        total++;
        if (state !== 2'b01) begin bad++; $display("FAIL restart_after: got %b expected 01", state); end
        press_start();
    endtask

    task automatic test_ack_abort();
        press_start();
        done = 1'b1;
        cyc(1);
        cyc(7);
        press_ack();
        total++;
        if (state !== 2'b00 || rounds_tens !== 4'd0 || rounds_ones !== 4'd3) begin
            bad++;
            $display("FAIL ack_in_alarm: got state=%b rounds=%h%h expected 00 03", state, rounds_tens, rounds_ones);
        end
        done = 1'b0;
        cyc(1);
        press_start();
        total++;
        if (state !== 2'b01) begin bad++; $display("FAIL abort_enter: got %b expected 01", state); end
        press_start();
        total++;
        if (state !== 2'b00 || rounds_ones !== 4'd3) begin
            bad++;
            $display("FAIL abort_run: got state=%b ones=%0d expected 00 3", state, rounds_ones);
        end
        press_start();
        start_key = 1'b0;
        cyc(1);
        start_key = 1'b1;
        cyc(1);
        done = 1'b1;
        cyc(1);
        total++;
        if (state !== 2'b10 || rounds_ones !== 4'd4) begin
            bad++;
            $display("FAIL start_and_done: got state=%b ones=%0d expected 10 4", state, rounds_ones);
        end
        press_ack();
        done = 1'b0;
        cyc(1);
    endtask

    task automatic test_wrap_guard();
        int cnt;
        cnt = 4;
        while (cnt < 99) begin
            do_round();
            cnt++;
            total++;
            if (rounds_tens !== 4'(cnt / 10) || rounds_ones !== 4'(cnt % 10)) begin
                bad++;
                $display("FAIL bcd_count: got %h%h expected %0d", rounds_tens, rounds_ones, cnt);
            end
        end
        do_round();
        total++;
        if (rounds_tens !== 4'd0 || rounds_ones !== 4'd0) begin
            bad++;
            $display("FAIL wrap_99: got %h%h expected 00", rounds_tens, rounds_ones);
        end
        done = 1'b1;
        cyc(2);
        press_start();
        cyc(4);
        total++;
        if (state !== 2'b00 || timer_run !== 1'b0) begin
            bad++;
            $display("FAIL idle_guard: got state=%b run=%b expected 00 0", state, timer_run);
        end
        done = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid_alarm();
        repeat (6) do_round();
        press_start();
        done = 1'b1;
        cyc(1);
        cyc(3);
        total++;
        if (state !== 2'b10 || rounds_tens !== 4'd0 || rounds_ones !== 4'd7) begin
            bad++;
            $display("FAIL pre_reset: got state=%b rounds=%h%h expected 10 07", state, rounds_tens, rounds_ones);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({state, timer_run, alarm_led, rounds_tens, rounds_ones} !== 12'h000) begin
            bad++;
            $display("FAIL async_reset: got state=%b run=%b led=%b rounds=%h%h expected 00 0 0 00",
                     state, timer_run, alarm_led, rounds_tens, rounds_ones);
        end
        done = 1'b0;
        cyc(1);
        resetn = 1'b1;
        cyc(2);
    endtask

    initial begin
        resetn    = 1'b0;
        start_key = 1'b1;
        ack_key   = 1'b1;
        done      = 1'b0;
        #2;
        test_reset();
        test_start_path();
        test_bounce();
        test_alarm_autoreturn();
        test_ack_abort();
        test_wrap_guard();
        test_reset_mid_alarm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
